// File: rtl/branch_sequencer_if.sv
// Branch sequencer bus: issue-side request, ALU compare handshake and PC-mux outputs.
// master = issue stage + ALU side, slave = branch_sequencer.
interface branch_sequencer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_funct3;
  logic             br_is_jump;
  logic [XLEN-1:0]  br_pc;
  logic [XLEN-1:0]  br_imm;
  logic             cmp_start;
  logic             cmp_done;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             flag_c;
  logic             pc_redirect;
  logic [XLEN-1:0]  pc_target;
  logic             flush;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, br_funct3, br_is_jump, br_pc, br_imm,
    output cmp_done, flag_z, flag_n, flag_v, flag_c,
    input  br_ready, cmp_start, pc_redirect, pc_target, flush, illegal, busy, taken_cnt
  );

  modport slave (
    input  br_valid, br_funct3, br_is_jump, br_pc, br_imm,
    input  cmp_done, flag_z, flag_n, flag_v, flag_c,
    output br_ready, cmp_start, pc_redirect, pc_target, flush, illegal, busy, taken_cnt
  );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle branch resolution: accept a branch/jump, run an ALU compare, evaluate
// the condition from the returned flags, then redirect the PC and flush younger work.
module branch_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_sequencer_if.slave  bus
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0] FcLoad = FcW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWait,
    StRedirect,
    StFlush
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_pc_target;
  logic             r_illegal;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [FcW-1:0]   r_flush_cnt;

  logic w_ready;
  logic w_accept;
  logic w_bad_f3;
  logic w_taken;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign w_ready  = (r_state == StIdle) && rst_n;
  assign w_accept = bus.br_valid && w_ready;
  assign w_bad_f3 = !bus.br_is_jump && (bus.br_funct3 inside {3'b010, 3'b011});

  always_comb begin
    w_taken = 1'b0;
    case (r_funct3)
      3'b000:  w_taken = bus.flag_z;
      3'b001:  w_taken = !bus.flag_z;
      3'b100:  w_taken = bus.flag_n ^ bus.flag_v;
      3'b101:  w_taken = !(bus.flag_n ^ bus.flag_v);
      3'b110:  w_taken = !bus.flag_c;
      3'b111:  w_taken = bus.flag_c;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (bus.br_is_jump)  w_state_next = StRedirect;
          else if (w_bad_f3)   w_state_next = StIdle;
          else                 w_state_next = StCompare;
        end
      end
      StCompare: w_state_next = StWait;
      StWait: begin
        if (bus.cmp_done) w_state_next = w_taken ? StRedirect : StIdle;
      end
      StRedirect: w_state_next = (FLUSH_CYCLES == 0) ? StIdle : StFlush;
      StFlush: begin
        if (r_flush_cnt == '0) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_funct3    <= '0;
      r_pc_target <= '0;
      r_illegal   <= 1'b0;
      r_taken_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_accept && w_bad_f3;
      if (w_accept) begin
        r_funct3    <= bus.br_funct3;
        r_pc_target <= bus.br_pc + bus.br_imm;
      end
      if (r_state == StRedirect) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        r_flush_cnt <= FcLoad;
      end else if (r_state == StFlush && r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - FcW'(1);
      end
    end
  end

  // Pulse outputs decode straight from state so an async reset clears them at once.
  assign bus.br_ready    = w_ready;
  assign bus.cmp_start   = (r_state == StCompare);
  assign bus.pc_redirect = (r_state == StRedirect);
  assign bus.flush       = (r_state == StFlush);
  assign bus.busy        = (r_state != StIdle);
  assign bus.illegal     = r_illegal;
  assign bus.pc_target   = r_pc_target;
  assign bus.taken_cnt   = r_taken_cnt;

endmodule
